// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter for the async FIFO write port
//
// Shares one FIFO write port among N valid/ready requesters in the write
// clock domain. A grant is held for up to MAX_BURST beats so each source's
// data lands contiguously in the FIFO. The FIFO full flag stalls beats
// without releasing the grant.
//
// Optional feature macro: FIFO_ARB_STATS_EN (adds beat_total, stall_cycles)
//
// Ports:
//   clk          in   write-domain clock (FIFO wclk)
//   rst          in   asynchronous active-low reset
//   in_valid     in   [N]     per-requester beat valid
//   in_data      in   [N*DW]  per-requester data, requester i at [i*DW +: DW]
//   in_ready     out  [N]     per-requester beat accepted
//   full         in   FIFO full flag
//   wen          out  FIFO write enable
//   wdata        out  [DW]    FIFO write data
//   grant        out  [N]     one-hot current owner, zero when idle
//   busy         out  high while a grant is active
//   beat_total   out  [16]    (FIFO_ARB_STATS_EN) wrapping beat count
//   stall_cycles out  [16]    (FIFO_ARB_STATS_EN) saturating full-stall count

module fifo_wr_arb #(
  parameter int N         = 4,
  parameter int DW        = 3,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  input  logic            full,
  output logic            wen,
  output logic [DW-1:0]   wdata,
  output logic [N-1:0]    grant,
  output logic            busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]     beat_total,
  output logic [15:0]     stall_cycles
`endif
);

  localparam int           PW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]  N_EXT    = (PW+1)'(N);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
  localparam logic [3:0]   LAST_BEAT = 4'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;

  // ---------------------------------------------------------------------
  // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then add rr_ptr back with an explicit wrap
  // (N need not be a power of two).
  // ---------------------------------------------------------------------
  logic [2*N-1:0]  valid_dbl;
  logic [N-1:0]    valid_rot;
  logic            sel_found;
  logic [PW-1:0]   sel_off;
  logic [PW:0]     sel_sum;
  logic [PW-1:0]   sel_idx;

  assign valid_dbl = {in_valid, in_valid} >> rr_ptr_q;
  assign valid_rot = valid_dbl[N-1:0];

  always_comb begin
    sel_found = 1'b0;
    sel_off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!sel_found && valid_rot[k]) begin
        sel_found = 1'b1;
        sel_off   = PW'(k);
      end
    end
  end

  assign sel_sum = {1'b0, rr_ptr_q} + {1'b0, sel_off};
  assign sel_idx = (sel_sum >= N_EXT) ? PW'(sel_sum - N_EXT) : sel_sum[PW-1:0];

  // ---------------------------------------------------------------------
  // Granted requester's valid and data
  // ---------------------------------------------------------------------
  logic            g_valid;
  logic [DW-1:0]   g_data;

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (gidx_q == PW'(k)) begin
        g_valid = in_valid[k];
        g_data  = in_data[k*DW +: DW];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wen         = 1'b0;
    in_ready    = '0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = BURST;
          grant_d     = {{(N-1){1'b0}}, 1'b1} << sel_idx;
          gidx_d      = sel_idx;
          burst_cnt_d = '0;
        end
      end

      BURST: begin
        busy     = 1'b1;
        // Ready follows full alone so a source can see acceptance without
        // a combinational path from its own valid back to its ready.
        in_ready = grant_q & {N{~full}};
        wen      = g_valid & ~full;
        if (wen) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
        // A drained source releases even while full is asserted, so an
        // empty requester never pins the port.
        if (!g_valid || (wen && (burst_cnt_q == LAST_BEAT))) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : PW'(gidx_q + 1'b1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign wdata = busy ? g_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // ---------------------------------------------------------------------
  // Statistics: beat_total wraps, stall_cycles saturates.
  // ---------------------------------------------------------------------
  logic [15:0] beat_total_q, beat_total_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        stall_now;

  assign stall_now = busy & g_valid & full;

  always_comb begin
    beat_total_d   = beat_total_q;
    stall_cycles_d = stall_cycles_q;
    if (wen) begin
      beat_total_d = beat_total_q + 16'd1;
    end
    if (stall_now && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_total_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      beat_total_q   <= beat_total_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign beat_total   = beat_total_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb

module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 3;
  localparam int MB = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            full;
  logic            wen;
  logic [DW-1:0]   wdata;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]     beat_total;
  logic [15:0]     stall_cycles;
`endif

  fifo_wr_arb #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .full         (full),
    .wen          (wen),
    .wdata        (wdata),
    .grant        (grant),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_total   (beat_total),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester i presents constant data i+1 in the table phase.
  localparam logic [N*DW-1:0] DATA_K = {3'd4, 3'd3, 3'd2, 3'd1};

  typedef struct {
    logic [N-1:0]  v;
    logic          f;
    logic [N-1:0]  eg;
    logic          ew;
    logic [DW-1:0] ewd;
    logic [N-1:0]  er;
    logic          eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [N-1:0] v, input logic f, input logic [N-1:0] eg,
                     input logic ew, input logic [DW-1:0] ewd, input logic [N-1:0] er,
                     input logic eb);
    vec_t t;
    t.v = v; t.f = f; t.eg = eg; t.ew = ew; t.ewd = ewd; t.er = er; t.eb = eb;
    vecs.push_back(t);
  endtask

  task automatic add_n(input int n, input logic [N-1:0] v, input logic f,
                       input logic [N-1:0] eg, input logic ew, input logic [DW-1:0] ewd,
                       input logic [N-1:0] er, input logic eb);
    for (int i = 0; i < n; i++) add(v, f, eg, ew, ewd, er, eb);
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    rst      = 1'b0;
    in_valid = '0;
    in_data  = '0;
    full     = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {grant, wen, wdata, in_ready, busy}, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int val;
  logic hs;
  logic [3:0] exp_g [9];
  logic       exp_w [9];
  logic [2:0] exp_d [9];
  logic       exp_b [9];

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    in_valid = '0;
    in_data  = '0;
    full     = 1'b0;
    #12;

    // ------------------------------------------------------------------
    // Table: round-robin, backpressure, early drain, drain under full
    // ------------------------------------------------------------------
    add  (4'hF, 0, 4'h0, 0, 3'd0, 4'h0, 0);
    add_n(4, 4'hF, 0, 4'h1, 1, 3'd1, 4'h1, 1);
    add  (4'hF, 0, 4'h0, 0, 3'd0, 4'h0, 0);
    add_n(4, 4'hF, 0, 4'h2, 1, 3'd2, 4'h2, 1);
    add  (4'hF, 0, 4'h0, 0, 3'd0, 4'h0, 0);
    add_n(4, 4'hF, 0, 4'h4, 1, 3'd3, 4'h4, 1);
    add  (4'hF, 0, 4'h0, 0, 3'd0, 4'h0, 0);
    add_n(4, 4'hF, 0, 4'h8, 1, 3'd4, 4'h8, 1);
    add  (4'hF, 0, 4'h0, 0, 3'd0, 4'h0, 0);
    add_n(2, 4'hF, 0, 4'h1, 1, 3'd1, 4'h1, 1);   // beats 1,2
    add_n(3, 4'hF, 1, 4'h1, 0, 3'd1, 4'h0, 1);   // full stall, grant held
    add_n(2, 4'hF, 0, 4'h1, 1, 3'd1, 4'h1, 1);   // beats 3,4 with no bubble
    add  (4'h4, 0, 4'h0, 0, 3'd0, 4'h0, 0);
    add  (4'h4, 0, 4'h4, 1, 3'd3, 4'h4, 1);      // requester 2 one beat
    add  (4'h8, 0, 4'h4, 0, 3'd3, 4'h4, 1);      // requester 2 drained
    add  (4'hC, 0, 4'h0, 0, 3'd0, 4'h0, 0);      // rr_ptr=3 picks 3 over 2
    add  (4'hC, 0, 4'h8, 1, 3'd4, 4'h8, 1);
    add  (4'h0, 1, 4'h8, 0, 3'd4, 4'h0, 1);      // drain while full exits
    add  (4'h0, 0, 4'h0, 0, 3'd0, 4'h0, 0);

    do_reset();
    foreach (vecs[i]) begin
      in_valid = vecs[i].v;
      in_data  = DATA_K;
      full     = vecs[i].f;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {grant, wen, wdata, in_ready, busy},
          {vecs[i].eg, vecs[i].ew, vecs[i].ewd, vecs[i].er, vecs[i].eb});
      @(posedge clk);
      #1;
    end

    // ------------------------------------------------------------------
    // Single source presenting 1..5 with a real handshake
    // ------------------------------------------------------------------
    exp_g = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
    exp_w = '{0, 1, 1, 1, 1, 0, 1, 0, 0};
    exp_d = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5, 3'd6, 3'd0};
    exp_b = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    do_reset();
    val = 1;
    for (int c = 0; c < 9; c++) begin
      in_valid = (val <= 5) ? 4'h1 : 4'h0;
      in_data  = {9'd0, 3'(val)};
      @(negedge clk);
      chk($sformatf("single_c%0d", c), {grant, wen, wdata, busy},
          {exp_g[c], exp_w[c], exp_d[c], exp_b[c]});
      hs = wen & in_ready[0];
      @(posedge clk);
      #1;
      if (hs) val++;
    end

    // ------------------------------------------------------------------
    // Async reset mid-burst, then arbitration restarts at requester 0
    // ------------------------------------------------------------------
    do_reset();
    in_valid = 4'h2;
    in_data  = DATA_K;
    repeat (7) begin
      @(posedge clk);
    end
    #1;
    #1;
    chk("prereset_grant", {grant, wen, wdata}, {4'h2, 1'b1, 3'd2});
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {grant, wen, in_ready, busy}, '0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 4'hF;
    @(negedge clk);
    chk("post_reset_idle", {grant, busy}, '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_reset_grant", {grant, wen, wdata}, {4'h1, 1'b1, 3'd1});
    @(posedge clk);
    #1;

`ifdef FIFO_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Stats: 10 beats, 3 stalled cycles
    // ------------------------------------------------------------------
    do_reset();
    chk("stats_reset", {beat_total, stall_cycles}, '0);
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 16) ? 4'h1 : 4'h0;
      in_data  = DATA_K;
      full     = (c >= 2 && c <= 4);
      @(posedge clk);
      #1;
    end
    chk("beat_total", {16'd0, beat_total}, 32'd10);
    chk("stall_cycles", {16'd0, stall_cycles}, 32'd3);
    do_reset();
    chk("stats_after_reset", {beat_total, stall_cycles}, '0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
